// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for a 5-stage pipeline.
// Shadows the EX/MEM/WB control fields needed to steer EX operands and stall IF/ID.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int FWD_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             hold,
  input  logic             flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             stall,
  output logic             ex_bubble
);

  localparam logic [FWD_W-1:0] SEL_RF  = FWD_W'(0);
  localparam logic [FWD_W-1:0] SEL_MEM = FWD_W'(1);
  localparam logic [FWD_W-1:0] SEL_WB  = FWD_W'(2);
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  logic             ex_valid, ex_rw, ex_mr;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_dst;
  logic             mem_valid, mem_rw;
  logic [REG_W-1:0] mem_dst;
  logic             wb_valid, wb_rw;
  logic [REG_W-1:0] wb_dst;

  logic mem_fwd_ok, wb_fwd_ok;

  assign mem_fwd_ok = mem_valid & mem_rw & (mem_dst != REG_ZERO);
  assign wb_fwd_ok  = wb_valid  & wb_rw  & (wb_dst  != REG_ZERO);

  // MEM is checked first so the younger result wins when both stages match.
  function automatic logic [FWD_W-1:0] pick_src(input logic [REG_W-1:0] src);
    if (mem_fwd_ok && (mem_dst == src))
      return SEL_MEM;
    else if (wb_fwd_ok && (wb_dst == src))
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  always_comb begin
    fwd_a = pick_src(ex_rs);
    fwd_b = pick_src(ex_rt);
  end

  assign stall = ex_valid & ex_mr & (ex_dst != REG_ZERO) & id_valid &
                 ((ex_dst == id_rs) | (ex_dst == id_rt));

  assign ex_bubble = ~hold & (stall | flush);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dst    <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_dst   <= '0;
      wb_valid  <= 1'b0;
      wb_rw     <= 1'b0;
      wb_dst    <= '0;
    end else if (!hold) begin
      wb_valid  <= mem_valid;
      wb_rw     <= mem_rw;
      wb_dst    <= mem_dst;
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_dst   <= ex_dst;
      // Fields are loaded even on a bubble; valid=0 makes them inert.
      ex_valid  <= id_valid & ~ex_bubble;
      ex_rw     <= id_reg_write;
      ex_mr     <= id_mem_read;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_dst    <= id_dst;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination-register and write/load flags for each instruction as it moves through EX, MEM and WB. Each cycle it produces the 2-bit operand-select codes consumed by the EX-stage operand forwarding multiplexers, plus the stall and bubble controls for the IF/ID front end. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and keeps its own shadow copy of the control fields it needs.

## Interface
Parameters:
- REG_W, 5, register-index width
- FWD_W, 2, select-code width (fixed encoding below)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_W  ID source register A
- id_rt  in  REG_W  ID source register B
- id_dst  in  REG_W  ID destination register (already muxed rd/rt)
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- hold  in  1  global freeze (e.g. memory wait); all stage state held
- flush  in  1  kill the instruction leaving ID (branch taken)
- fwd_a  out  FWD_W  EX operand A select
- fwd_b  out  FWD_W  EX operand B select
- stall  out  1  hold PC and IF/ID register
- ex_bubble  out  1  ID/EX receives a NOP this edge

## Operation
- Select encoding, shared with the forwarding multiplexers:
  - 2'b00: register-file read data
  - 2'b01: EX/MEM ALU result
  - 2'b10: MEM/WB write-back result
  - 2'b11: never driven
- Internal stage registers: EX{valid,rs,rt,dst,rw,mr}, MEM{valid,dst,rw,mr}, WB{valid,dst,rw}.
- fwd_a for the EX-stage rs, evaluated in priority order:
  - 01 if MEM.valid & MEM.rw & MEM.dst!=0 & MEM.dst==EX.rs
  - else 10 if WB.valid & WB.rw & WB.dst!=0 & WB.dst==EX.rs
  - else 00
  - If both MEM and WB match, 01 wins (younger result).
- fwd_b: same rules using EX.rt.
- Register 0 is never forwarded.
- Load-use stall:
  - stall = EX.valid & EX.mr & EX.dst!=0 & id_valid & (EX.dst==id_rs | EX.dst==id_rt)
  - A load in MEM needs no stall; it is covered by the 10 path next cycle.
- ex_bubble = stall | flush, suppressed while hold=1.
- Per-edge update:
  - hold=1: all stage registers keep their values.
  - else: WB<=MEM and MEM<=EX.
  - EX <= ID fields if !ex_bubble; otherwise EX.valid<=0 with the other EX fields don't-care.
  - ID fields with id_valid=0 load EX.valid=0.
- Priority: reset > hold > flush > load-use bubble > normal advance.

## Timing
- Reset: every stage valid=0. The outputs therefore read fwd_a=fwd_b=00, stall=0, ex_bubble=0 from the first cycle after the reset edge.
- rst_n asserted mid-operation clears all in-flight state at that edge. No forwarding is issued afterwards for pre-reset instructions.
- fwd_a, fwd_b and stall are combinational from the stage registers and ID inputs, valid in the same cycle. There is no added latency.
- Load-use: stall stays high exactly one cycle, unless hold is asserted, in which case it persists. After the bubble edge the load is in MEM and stall drops. The dependent instruction then enters EX one edge later and sees 10.
- hold and stall together: stall may be high, but the stage registers do not move and ex_bubble=0.
- flush and stall together: a single bubble is inserted. stall still holds IF/ID; the front end decides what to discard.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: add r3 (dst=3,rw=1) then sub with rs=3, rt=4.
  - Required: when sub is in EX, fwd_a=01, fwd_b=00, stall=0.
- Two-apart dependency plus priority:
  - Stimulus: r5 written by instructions at EX-2 and EX-1; EX reads rt=5.
  - Required: fwd_b=01. With only the EX-2 writer, fwd_b=10.
- Load-use:
  - Stimulus: lw dst=8 then add rs=8.
  - Required: stall=1 and ex_bubble=1 for one cycle. Next edge: EX.valid=0. The add then enters EX with fwd_a=10.
- Register zero:
  - Stimulus: writer with dst=0, rw=1, then reader rs=0.
  - Required: fwd_a=00. A load with dst=0 followed by a user of r0 gives stall=0.
- hold and flush:
  - Stimulus: assert hold during a load-use for 3 cycles.
  - Required: stage state is unchanged, stall stays 1, and ex_bubble=0 throughout.
  - Stimulus: flush with id_valid=1.
  - Required: EX.valid=0 next cycle, and no forwarding from it in later cycles.
- Reset mid-stream:
  - Stimulus: pipeline full of writers to r2, then rst_n=0 for one edge.
  - Required: next cycle fwd_a=fwd_b=00 and stall=0 for any rs/rt.
